// File: rtl/ls_port_arbiter.sv
// ls_port_arbiter
// Arbitrates the single-ported local store between DMA, the MEM-stage
// load/store path and instruction fetch. Issues at most one LS access per
// cycle, tags in-flight reads so returning data reaches its owner, and asks
// the pipeline to stall while a load/store is being held off.
module ls_port_arbiter #(
    parameter int LS_AW        = 14, // quadword index width
    parameter int LS_LAT       = 3,  // ls_en -> ls_rdata latency (1..7)
    parameter int STARVE_LIMIT = 8   // denied cycles before fetch is forced (1..15)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [31:0]      dma_addr,
    input  logic [127:0]     dma_wdata,
    output logic             dma_gnt,

    input  logic             lsu_req,
    input  logic             lsu_we,
    input  logic [31:0]      lsu_addr,
    input  logic [127:0]     lsu_wdata,
    output logic             lsu_gnt,

    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,

    output logic             ls_en,
    output logic             ls_we,
    output logic [LS_AW-1:0] ls_addr,
    output logic [127:0]     ls_wdata,
    input  logic [127:0]     ls_rdata,

    output logic             rd_valid,
    output logic [1:0]       rd_id,
    output logic [127:0]     rd_data,

    output logic             stall_req
);

    // Requester encoding doubles as the rd_id tag returned with read data.
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_DMA  = 2'b01,
        SRC_LSU  = 2'b10,
        SRC_IF   = 2'b11
    } src_e;

    localparam int CNT_W = 4;

    // ------------------------------------------------------------------
    // Address mapping
    // ------------------------------------------------------------------
    // Addresses use big-endian bit numbering, so bits [28-LS_AW:27] are the
    // little-endian bits [LS_AW+3:4]: the byte offset within the quadword is
    // dropped and everything above the index wraps modulo the store size.
    logic [LS_AW-1:0] dma_idx;
    logic [LS_AW-1:0] lsu_idx;
    logic [LS_AW-1:0] if_idx;

    assign dma_idx = dma_addr[LS_AW+3:4];
    assign lsu_idx = lsu_addr[LS_AW+3:4];
    assign if_idx  = if_addr[LS_AW+3:4];

    // Byte offsets and wrapped upper bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dma_addr[31:LS_AW+4], dma_addr[3:0],
                                lsu_addr[31:LS_AW+4], lsu_addr[3:0],
                                if_addr[31:LS_AW+4],  if_addr[3:0]};

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] starve_cnt;
    logic             if_force;
    src_e             gnt_src;

    // Fetch jumps to the front once it has been denied STARVE_LIMIT times.
    assign if_force = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Pick the single winner: forced fetch, then DMA > LSU > IF.
    always_comb begin
        // NOTE: default first so every path assigns gnt_src and no latch is inferred.
        gnt_src = SRC_NONE;
        if (rst) begin
            gnt_src = SRC_NONE;
        end else if (if_force) begin
            gnt_src = SRC_IF;
        end else if (dma_req) begin
            gnt_src = SRC_DMA;
        end else if (lsu_req) begin
            gnt_src = SRC_LSU;
        end else if (if_req) begin
            gnt_src = SRC_IF;
        end
    end

    assign dma_gnt = (gnt_src == SRC_DMA);
    assign lsu_gnt = (gnt_src == SRC_LSU);
    assign if_gnt  = (gnt_src == SRC_IF);

    // A held-off load/store freezes the MEM stage until it wins.
    assign stall_req = lsu_req && !lsu_gnt && !rst;

    // ------------------------------------------------------------------
    // Winner's command fields
    // ------------------------------------------------------------------
    logic             sel_we;
    logic [LS_AW-1:0] sel_addr;
    logic [127:0]     sel_wdata;
    logic             sel_has_data;

    // Route the granted requester's write flag, index and data to the LS port.
    always_comb begin
        sel_we       = 1'b0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_has_data = 1'b0;
        case (gnt_src)
            SRC_DMA: begin
                sel_we       = dma_we;
                sel_addr     = dma_idx;
                sel_wdata    = dma_wdata;
                sel_has_data = 1'b1;
            end
            SRC_LSU: begin
                sel_we       = lsu_we;
                sel_addr     = lsu_idx;
                sel_wdata    = lsu_wdata;
                sel_has_data = 1'b1;
            end
            SRC_IF: begin
                // Fetch never writes.
                sel_we   = 1'b0;
                sel_addr = if_idx;
            end
            default: begin
                sel_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------
    // Count consecutive denied fetch cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_req && !if_gnt) begin
            if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered LS port
    // ------------------------------------------------------------------
    src_e ls_src; // owner of the access currently on the LS port

    // Launch the cycle-T grant onto the LS port in cycle T+1; hold addr/data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_en    <= 1'b0;
            ls_we    <= 1'b0;
            ls_addr  <= '0;
            ls_wdata <= '0;
            ls_src   <= SRC_NONE;
        end else begin
            ls_en  <= (gnt_src != SRC_NONE);
            ls_we  <= sel_we;
            ls_src <= gnt_src;
            if (gnt_src != SRC_NONE) begin
                ls_addr <= sel_addr;
            end
            if (sel_has_data) begin
                ls_wdata <= sel_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight read tracking
    // ------------------------------------------------------------------
    // Stage k holds the access issued k+1 cycles ago; the last stage lines up
    // with the cycle in which ls_rdata is valid for that access.
    logic [LS_LAT-1:0]      pipe_vld;
    logic [LS_LAT-1:0][1:0] pipe_id;

    // Shift {valid, owner} along with the LS read latency; writes enter as invalid.
    always_ff @(posedge clk) begin
        // NOTE: the tag pipe is reset (unlike a data RAM) so a reset flushes reads already in flight.
        if (rst) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld[0] <= ls_en && !ls_we;
            pipe_id[0]  <= ls_src;
            for (int i = 1; i < LS_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    // Capture returning read data with its owner tag; hold data between returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_id    <= 2'b00;
            rd_data  <= '0;
        end else begin
            rd_valid <= pipe_vld[LS_LAT-1];
            if (pipe_vld[LS_LAT-1]) begin
                rd_id   <= pipe_id[LS_LAT-1];
                rd_data <= ls_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Directed testbench for ls_port_arbiter with a behavioural local store
// whose read data appears LS_LAT cycles after ls_en.
module tb_ls_port_arbiter;

    localparam int LS_AW        = 14;
    localparam int LS_LAT       = 3;
    localparam int STARVE_LIMIT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             dma_req, dma_we;
    logic [31:0]      dma_addr;
    logic [127:0]     dma_wdata;
    logic             dma_gnt;
    logic             lsu_req, lsu_we;
    logic [31:0]      lsu_addr;
    logic [127:0]     lsu_wdata;
    logic             lsu_gnt;
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_gnt;
    logic             ls_en, ls_we;
    logic [LS_AW-1:0] ls_addr;
    logic [127:0]     ls_wdata;
    logic [127:0]     ls_rdata;
    logic             rd_valid;
    logic [1:0]       rd_id;
    logic [127:0]     rd_data;
    logic             stall_req;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    ls_port_arbiter #(
        .LS_AW(LS_AW), .LS_LAT(LS_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
        .stall_req(stall_req)
    );

    // Local store model: every quadword starts as its index repeated 8 times.
    logic [127:0]     mem [0:(1<<LS_AW)-1];
    logic [LS_AW-1:0] rd_pipe [LS_LAT];

    initial begin
        for (int i = 0; i < (1 << LS_AW); i++) mem[i] = {8{16'(i)}};
        for (int i = 0; i < LS_LAT; i++) rd_pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (ls_en && ls_we) mem[ls_addr] <= ls_wdata;
        rd_pipe[0] <= ls_addr;
        for (int i = 1; i < LS_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign ls_rdata = mem[rd_pipe[LS_LAT-1]];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0;
        if_req  = 0; if_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_ls_en",    128'(ls_en), 128'd0);
        check("rst_ls_we",    128'(ls_we), 128'd0);
        check("rst_ls_addr",  128'(ls_addr), 128'd0);
        check("rst_ls_wdata", ls_wdata, 128'd0);
        check("rst_rd_valid", 128'(rd_valid), 128'd0);
        check("rst_rd_id",    128'(rd_id), 128'd0);
        check("rst_rd_data",  rd_data, 128'd0);
        check("rst_stall",    128'(stall_req), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- Single LSU load ----
        @(negedge clk);
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0120;
        #1;
        check("t1_lsu_gnt", 128'(lsu_gnt), 128'd1);
        check("t1_dma_gnt", 128'(dma_gnt), 128'd0);
        check("t1_if_gnt",  128'(if_gnt), 128'd0);
        check("t1_stall",   128'(stall_req), 128'd0);
        @(negedge clk);
        idle();
        #1;
        check("t1_ls_en",   128'(ls_en), 128'd1);
        check("t1_ls_we",   128'(ls_we), 128'd0);
        check("t1_ls_addr", 128'(ls_addr), 128'h0012);
        @(negedge clk); #1;
        check("t1_ls_en_off", 128'(ls_en), 128'd0);
        @(negedge clk);
        @(negedge clk); #1;
        check("t1_rd_early", 128'(rd_valid), 128'd0);
        @(negedge clk); #1;
        check("t1_rd_valid", 128'(rd_valid), 128'd1);
        check("t1_rd_id",    128'(rd_id), 128'd2);
        check("t1_rd_data",  rd_data, {8{16'h0012}});

        // ---- Three-way contention ----
        @(negedge clk);
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0100;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0200;
        if_req  = 1; if_addr = 32'h0000_0300;
        #1;
        check("t2_dma_gnt", 128'(dma_gnt), 128'd1);
        check("t2_lsu_gnt", 128'(lsu_gnt), 128'd0);
        check("t2_if_gnt",  128'(if_gnt), 128'd0);
        check("t2_stall",   128'(stall_req), 128'd1);
        @(negedge clk);
        dma_req = 0;
        #1;
        check("t2_lsu_gnt2", 128'(lsu_gnt), 128'd1);
        check("t2_stall2",   128'(stall_req), 128'd0);
        check("t2_addr_dma", 128'(ls_addr), 128'h0010);
        @(negedge clk);
        lsu_req = 0;
        #1;
        check("t2_if_gnt3",  128'(if_gnt), 128'd1);
        check("t2_addr_lsu", 128'(ls_addr), 128'h0020);
        @(negedge clk);
        idle();
        #1;
        check("t2_addr_if", 128'(ls_addr), 128'h0030);
        check("t2_we_if",   128'(ls_we), 128'd0);
        @(negedge clk); #1;
        check("t2_rd_none", 128'(rd_valid), 128'd0);
        @(negedge clk); #1;
        check("t2_rd0_v",  128'(rd_valid), 128'd1);
        check("t2_rd0_id", 128'(rd_id), 128'd1);
        check("t2_rd0_d",  rd_data, {8{16'h0010}});
        @(negedge clk); #1;
        check("t2_rd1_v",  128'(rd_valid), 128'd1);
        check("t2_rd1_id", 128'(rd_id), 128'd2);
        check("t2_rd1_d",  rd_data, {8{16'h0020}});
        @(negedge clk); #1;
        check("t2_rd2_v",  128'(rd_valid), 128'd1);
        check("t2_rd2_id", 128'(rd_id), 128'd3);
        check("t2_rd2_d",  rd_data, {8{16'h0030}});
        @(negedge clk); #1;
        check("t2_rd_end",  128'(rd_valid), 128'd0);
        check("t2_rd_hold", rd_data, {8{16'h0030}});

        // ---- Starvation override ----
        @(negedge clk);
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0400;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0500;
        if_req  = 1; if_addr = 32'h0000_0600;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check($sformatf("t3_if_denied_%0d", i), 128'(if_gnt), 128'd0);
            check($sformatf("t3_dma_won_%0d", i),   128'(dma_gnt), 128'd1);
        end
        @(negedge clk); #1;
        check("t3_if_forced", 128'(if_gnt), 128'd1);
        check("t3_dma_lost",  128'(dma_gnt), 128'd0);
        check("t3_lsu_lost",  128'(lsu_gnt), 128'd0);
        check("t3_stall",     128'(stall_req), 128'd1);
        @(negedge clk); #1;
        check("t3_cnt_clear", 128'(dut.starve_cnt), 128'd0);
        check("t3_if_again",  128'(if_gnt), 128'd0);
        check("t3_dma_again", 128'(dma_gnt), 128'd1);
        check("t3_if_addr",   128'(ls_addr), 128'h0060);
        @(negedge clk);
        idle();
        repeat (LS_LAT + 3) @(negedge clk);

        // ---- DMA write then LSU read, same index ----
        @(negedge clk);
        dma_req = 1; dma_we = 1; dma_addr = 32'h0000_3FF0; dma_wdata = {16{8'hA5}};
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_3FF0;
        #1;
        check("t4_dma_gnt", 128'(dma_gnt), 128'd1);
        check("t4_stall",   128'(stall_req), 128'd1);
        @(negedge clk);
        dma_req = 0; dma_we = 0;
        #1;
        check("t4_lsu_gnt",  128'(lsu_gnt), 128'd1);
        check("t4_w_en",     128'(ls_en), 128'd1);
        check("t4_w_we",     128'(ls_we), 128'd1);
        check("t4_w_addr",   128'(ls_addr), 128'h03FF);
        check("t4_w_wdata",  ls_wdata, {16{8'hA5}});
        @(negedge clk);
        idle();
        #1;
        check("t4_r_en",   128'(ls_en), 128'd1);
        check("t4_r_we",   128'(ls_we), 128'd0);
        check("t4_r_addr", 128'(ls_addr), 128'h03FF);
        for (int i = 0; i < LS_LAT; i++) begin
            @(negedge clk); #1;
            check($sformatf("t4_no_wr_rd_%0d", i), 128'(rd_valid), 128'd0);
        end
        @(negedge clk); #1;
        check("t4_rd_valid", 128'(rd_valid), 128'd1);
        check("t4_rd_id",    128'(rd_id), 128'd2);
        check("t4_rd_data",  rd_data, {16{8'hA5}});

        // ---- Address wrap ----
        @(negedge clk);
        lsu_req = 1; lsu_we = 1; lsu_addr = 32'hFFFC_0010;
        lsu_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1;
        check("t5_lsu_gnt", 128'(lsu_gnt), 128'd1);
        @(negedge clk);
        idle();
        #1;
        check("t5_ls_addr",  128'(ls_addr), 128'h0001);
        check("t5_ls_we",    128'(ls_we), 128'd1);
        check("t5_ls_wdata", ls_wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        @(negedge clk); #1;
        check("t5_idle_en",   128'(ls_en), 128'd0);
        check("t5_idle_we",   128'(ls_we), 128'd0);
        check("t5_addr_hold", 128'(ls_addr), 128'h0001);

        // ---- Reset with reads in flight ----
        @(negedge clk);
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0700;
        @(negedge clk);
        lsu_addr = 32'h0000_0710;
        #1;
        check("t6_en0",   128'(ls_en), 128'd1);
        check("t6_addr0", 128'(ls_addr), 128'h0070);
        @(negedge clk);
        idle();
        #1;
        check("t6_en1",   128'(ls_en), 128'd1);
        check("t6_addr1", 128'(ls_addr), 128'h0071);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("t6_ls_en",    128'(ls_en), 128'd0);
        check("t6_ls_we",    128'(ls_we), 128'd0);
        check("t6_ls_addr",  128'(ls_addr), 128'd0);
        check("t6_ls_wdata", ls_wdata, 128'd0);
        check("t6_rd_valid", 128'(rd_valid), 128'd0);
        check("t6_rd_id",    128'(rd_id), 128'd0);
        check("t6_rd_data",  rd_data, 128'd0);
        check("t6_stall",    128'(stall_req), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LS_LAT + 2; i++) begin
            #1;
            check($sformatf("t6_flushed_%0d", i), 128'(rd_valid), 128'd0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
